// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared playfield types and constants for the Tetris datapath.
//               It provides the grid geometry, the cell encoding, the row type,
//               the line-clear FSM states and the line-clear score table.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int GRID_W = 10;
    localparam int GRID_H = 22;

    typedef logic [3:0] cell_t;

    localparam cell_t CELL_EMPTY  = 4'd0;
    localparam cell_t CELL_ACTIVE = 4'd1;
    localparam cell_t CELL_LOCKED = 4'd2;

    typedef cell_t [GRID_W-1:0] row_t;

    typedef enum logic [1:0] {
        LC_IDLE  = 2'd0,
        LC_SCAN  = 2'd1,
        LC_SHIFT = 2'd2,
        LC_DONE  = 2'd3
    } lc_state_e;

    // Points awarded for the number of rows removed in one pass
    localparam logic [10:0] SCORE_0_LINES = 11'd0;
    localparam logic [10:0] SCORE_1_LINE  = 11'd40;
    localparam logic [10:0] SCORE_2_LINES = 11'd100;
    localparam logic [10:0] SCORE_3_LINES = 11'd300;
    localparam logic [10:0] SCORE_4_LINES = 11'd1200;

    // Four or more rows in one pass all earn the top award
    function automatic logic [10:0] line_score(input logic [4:0] n_lines);
        logic [10:0] pts;
        case (n_lines)
            5'd0:    pts = SCORE_0_LINES;
            5'd1:    pts = SCORE_1_LINE;
            5'd2:    pts = SCORE_2_LINES;
            5'd3:    pts = SCORE_3_LINES;
            default: pts = SCORE_4_LINES;
        endcase
        return pts;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_clear_ctrl_row_full_detect.sv
`default_nettype none
// ============================================================================
// Module      : row_full_detect
// Description : Combinational check that every cell of one playfield row is
//               occupied (non-zero).
// Revision    : 1.0 - initial release
// ============================================================================
module row_full_detect
    import tetris_pkg::*;
#(
    parameter int ROW_W = tetris_pkg::GRID_W
) (
    input  cell_t [ROW_W-1:0] row,
    output logic              full
);

    logic [ROW_W-1:0] cell_occupied;

    generate
        for (genvar x = 0; x < ROW_W; x++) begin : g_cell
            assign cell_occupied[x] = (row[x] != CELL_EMPTY);
        end
    endgenerate

    assign full = &cell_occupied;

endmodule
`default_nettype wire

// File: rtl/line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_clear_ctrl
// Description : Line-clear sequencer. A start request snapshots the playfield.
//               The block scans rows bottom to top and collapses each full row
//               by moving the rows above it down one row per cycle. The result
//               is returned with a single-cycle write strobe.
//               Optional feature macro: LINE_CLEAR_SCORE_EN. When it is defined,
//               a saturating score accumulator is built. When it is undefined,
//               the score output is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module line_clear_ctrl #(
    parameter int GRID_W  = tetris_pkg::GRID_W,
    parameter int GRID_H  = tetris_pkg::GRID_H,
    parameter int SCORE_W = 16
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic                                start,
    input  logic [GRID_H-1:0][GRID_W-1:0][3:0]  grid_in,
    output logic [GRID_H-1:0][GRID_W-1:0][3:0]  grid_out,
    output logic                                grid_we,
    output logic                                busy,
    output logic                                done,
    output logic [4:0]                          lines_cleared,
    output logic [SCORE_W-1:0]                  score
);

    import tetris_pkg::*;

    localparam int YW = $clog2(GRID_H);

    lc_state_e                          state_q, state_d;
    logic [YW-1:0]                      y_q, y_d;
    logic [YW-1:0]                      k_q, k_d;
    cell_t [GRID_H-1:0][GRID_W-1:0]     grid_q, grid_d;
    logic [4:0]                         lines_q, lines_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               we_q, we_d;
    logic                               row_full;

    row_full_detect #(
        .ROW_W (GRID_W)
    ) u_row_full_detect (
        .row  (grid_q[y_q]),
        .full (row_full)
    );

    // Next-state logic: scan upward and collapse full rows in the working copy
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        k_d     = k_q;
        grid_d  = grid_q;
        lines_d = lines_q;
        case (state_q)
            LC_IDLE: begin
                if (start) begin
                    grid_d  = grid_in;
                    y_d     = YW'(GRID_H - 1);
                    lines_d = '0;
                    state_d = LC_SCAN;
                end
            end
            LC_SCAN: begin
                if (row_full) begin
                    lines_d = lines_q + 5'd1;
                    k_d     = y_q;
                    state_d = LC_SHIFT;
                end else if (y_q == '0) begin
                    state_d = LC_DONE;
                end else begin
                    y_d = y_q - YW'(1);
                end
            end
            LC_SHIFT: begin
                // y is left unchanged so the row that drops into it gets rescanned
                if (k_q != '0) begin
                    grid_d[k_q] = grid_q[k_q - YW'(1)];
                    k_d         = k_q - YW'(1);
                end else begin
                    grid_d[0] = '0;
                    state_d   = LC_SCAN;
                end
            end
            LC_DONE: begin
                state_d = LC_IDLE;
            end
            default: begin
                state_d = LC_IDLE;
            end
        endcase
        // Status outputs are registered, so they are computed from the next state
        busy_d = (state_d != LC_IDLE);
        done_d = (state_d == LC_DONE);
        we_d   = (state_d == LC_DONE);
    end

    // State, working grid and registered status flags
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= LC_IDLE;
            y_q     <= '0;
            k_q     <= '0;
            grid_q  <= '0;
            lines_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            k_q     <= k_d;
            grid_q  <= grid_d;
            lines_q <= lines_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
        end
    end

    assign grid_out      = grid_q;
    assign grid_we       = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign lines_cleared = lines_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W:0]   score_sum;

    // Award is added as the pass enters DONE, so score is current with done
    always_comb begin
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(line_score(lines_q));
        score_d   = score_q;
        if ((state_q == LC_SCAN) && (state_d == LC_DONE)) begin
            score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
    end

    // Score accumulator; only reset clears it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_clear_ctrl
// Description : Self-checking bench for line_clear_ctrl. A behavioural model
//               compacts the grid, counts the cleared rows and derives the pass
//               length. One compare process checks the DUT against it on every
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_clear_ctrl;

    localparam int GW = 10;
    localparam int GH = 22;
    localparam int SW = 16;
    localparam int SMAX = 65535;

    typedef logic [GH-1:0][GW-1:0][3:0] grid_t;

    logic           Clk = 1'b0;
    logic           Reset_n = 1'b0;
    logic           start = 1'b0;
    grid_t          grid_in = '0;
    grid_t          grid_out;
    logic           grid_we, busy, done;
    logic [4:0]     lines_cleared;
    logic [SW-1:0]  score;

    line_clear_ctrl #(.GRID_W(GW), .GRID_H(GH), .SCORE_W(SW)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .start         (start),
        .grid_in       (grid_in),
        .grid_out      (grid_out),
        .grid_we       (grid_we),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    always #5 Clk = ~Clk;

    int    checks = 0;
    int    errors = 0;
    bit    model_on = 0;
    int    cyc = 0;
    int    exp_T = 0;
    int    exp_lines = 0;
    int    exp_score = 0;
    grid_t exp_grid = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_grid(input string name, input grid_t act, input grid_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit row_is_full(input grid_t g, input int y);
        for (int x = 0; x < GW; x++) if (g[y][x] == 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Expected result: surviving rows keep their order and drop to the bottom.
    // A removed row costs (its position at removal time + 1) shift cycles.
    function automatic void model_pass(input grid_t g, output grid_t r,
                                       output int n, output int t);
        int dst;
        int shift_cycles;
        dst = GH - 1;
        shift_cycles = 0;
        n = 0;
        r = '0;
        for (int y = GH - 1; y >= 0; y--) begin
            if (row_is_full(g, y)) begin
                shift_cycles += (y + n) + 1;
                n++;
            end else begin
                r[dst] = g[y];
                dst--;
            end
        end
        t = GH + n + shift_cycles + 1;
    endfunction

    function automatic int award(input int n);
        case (n)
            0: return 0;
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
    endfunction

    function automatic grid_t random_grid();
        grid_t g;
        int kind;
        g = '0;
        for (int y = 0; y < GH; y++) begin
            kind = $urandom_range(0, 3);
            for (int x = 0; x < GW; x++) begin
                case (kind)
                    0: g[y][x] = 4'($urandom_range(1, 15));
                    1: g[y][x] = 4'd0;
                    default: g[y][x] = 4'($urandom_range(0, 2));
                endcase
            end
        end
        return g;
    endfunction

    // Compare process: pass timing, result and idle behaviour on every cycle
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (model_on) begin
                cyc++;
                chk("busy", busy, cyc <= exp_T);
                chk("done", done, cyc == exp_T);
                chk("grid_we", grid_we, cyc == exp_T);
                if (cyc == exp_T) begin
                    chk_grid("grid_out_at_done", grid_out, exp_grid);
                    chk("lines_at_done", lines_cleared, exp_lines);
                    chk("score_at_done", score, exp_score);
                end
                if (cyc > exp_T) model_on = 0;
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_we", grid_we, 0);
                chk("idle_lines", lines_cleared, exp_lines);
                chk("idle_score", score, exp_score);
                chk_grid("idle_grid", grid_out, exp_grid);
            end
        end
    end

    task automatic do_start(input grid_t g);
        grid_t r;
        int n, t;
        @(negedge Clk);
        #2;
        model_pass(g, r, n, t);
        grid_in   = g;
        start     = 1'b1;
        exp_grid  = r;
        exp_lines = n;
        exp_T     = t;
`ifdef LINE_CLEAR_SCORE_EN
        exp_score = (exp_score + award(n) > SMAX) ? SMAX : exp_score + award(n);
`endif
        cyc      = 0;
        model_on = 1;
        @(posedge Clk);
        #2;
        start   = 1'b0;
        grid_in = random_grid();
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && model_on; i++) @(posedge Clk);
        checks++;
        if (model_on) begin
            errors++;
            $display("FAIL pass_timeout: pass still running after %0d cycles", budget);
            model_on = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        Reset_n  = 1'b0;
        model_on = 0;
        exp_score = 0;
        exp_lines = 0;
        exp_grid  = '0;
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_we"}, grid_we, 0);
        chk({tag, "_lines"}, lines_cleared, 0);
        chk({tag, "_score"}, score, 0);
        chk_grid({tag, "_grid"}, grid_out, '0);
    endtask

    grid_t g;

    initial begin
        // Reset state
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge Clk);
        #2;
        Reset_n = 1'b1;

        // Empty grid: 23 busy cycles, nothing cleared
        g = '0;
        do_start(g);
        chk("model_T_empty", exp_T, 23);
        wait_idle(200);
        chk("lines_empty", lines_cleared, 0);

        // Bottom row full plus one locked cell above it
        g = '0;
        for (int x = 0; x < GW; x++) g[21][x] = 4'd2;
        g[20][0] = 4'd2;
        do_start(g);
        chk("model_T_row21", exp_T, 46);
        chk("model_lines_row21", exp_lines, 1);
        wait_idle(200);
        chk("row21_cell0", grid_out[21][0], 2);
        chk("row20_empty", grid_out[20], 0);
        chk("lines_row21", lines_cleared, 1);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_row21", score, 40);
`else
        chk("score_row21", score, 0);
`endif

        // Four full rows and nothing else
        do_reset();
        g = '0;
        for (int y = 18; y < 22; y++)
            for (int x = 0; x < GW; x++) g[y][x] = 4'(1 + ((x + y) % 2));
        do_start(g);
        chk("model_T_tetris", exp_T, 115);
        wait_idle(400);
        chk_grid("tetris_grid_empty", grid_out, '0);
        chk("lines_tetris", lines_cleared, 4);
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_tetris", score, 1200);
`else
        chk("score_tetris", score, 0);
`endif

        // A second start during a pass must be ignored
        do_start(random_grid());
        for (int i = 0; i < 20 && cyc < 5; i++) @(posedge Clk);
        #2;
        grid_in = random_grid();
        start = 1'b1;
        @(posedge Clk);
        #2;
        start = 1'b0;
        wait_idle(1000);

        // Randomized passes
        for (int p = 0; p < 12; p++) begin
            do_start(random_grid());
            wait_idle(1000);
            repeat ($urandom_range(0, 3)) @(posedge Clk);
        end

        // Reset in the middle of a pass aborts it with no write strobe
        g = '0;
        for (int x = 0; x < GW; x++) g[21][x] = 4'd2;
        do_start(g);
        for (int i = 0; i < 20 && cyc < 10; i++) @(posedge Clk);
        #2;
        Reset_n  = 1'b0;
        model_on = 0;
        #1;
        check_zero_outputs("abort");
        exp_score = 0;
        exp_lines = 0;
        exp_grid  = '0;
        repeat (2) begin
            @(negedge Clk);
            chk("abort_held_we", grid_we, 0);
        end
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        do_start(g);
        wait_idle(200);
        chk("after_abort_lines", lines_cleared, 1);

        // Score saturation with repeated four-row passes
        do_reset();
        g = '0;
        for (int y = 18; y < 22; y++)
            for (int x = 0; x < GW; x++) g[y][x] = 4'd2;
        for (int p = 0; p < 56; p++) begin
            do_start(g);
            wait_idle(400);
        end
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_saturated", score, 16'hFFFF);
`else
        chk("score_disabled", score, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_clear_ctrl.md
# line_clear_ctrl

Sequencer that runs the line-clear pass on the Tetris playfield after a piece locks. On a start pulse it snapshots the 10x22 grid, scans rows bottom to top, and collapses every full row by shifting the rows above it down one row per cycle. It then hands the updated grid back to the playfield owner with a one-cycle write strobe. It sits between the piece/lock logic, which issues start, and the grid register that feeds color_mapper.

## Interface
Parameters:
- GRID_W, default 10: columns (x index).
- GRID_H, default 22: rows (y index). Rows 0-1 are hidden and rows 2-21 are displayed.
- SCORE_W, default 16: score accumulator width.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run a clear pass. Sampled only in IDLE.
- grid_in  in  [3:0] x [GRID_W][GRID_H]  current playfield, captured on an accepted start.
- grid_out  out  [3:0] x [GRID_W][GRID_H]  working copy; valid when done=1.
- grid_we  out  1  one-cycle strobe; the owner loads grid_out on this cycle.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse, coincident with grid_we.
- lines_cleared  out  5  number of rows removed in the last pass.
- score  out  SCORE_W  accumulated score (see Configuration).

## Operation
- Cell encoding: 0 = empty, 1 = active piece, 2 = locked. A row is full when all GRID_W cells are non-zero.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - Accepted start: capture grid_in into the working copy, set y = GRID_H-1, clear lines_cleared, go to SCAN.
  - start during any other state is ignored; there is no queueing.
- SCAN, one row per cycle:
  - If row y is full: increment lines_cleared, set k = y, go to SHIFT.
  - Else if y == 0: go to DONE.
  - Else: y decrements.
- SHIFT, one row per cycle:
  - For k ≥ 1: row k ← row k-1, then k decrements.
  - For k == 0: row 0 ← all empty, then return to SCAN at the same y, because a new row has moved into y.
  - So SHIFT lasts y+1 cycles.
- DONE: assert grid_we and done for one cycle, then go to IDLE. busy drops on the following cycle.
- lines_cleared holds its value until the next accepted start. Maximum value is GRID_H = 22, so it needs 5 bits.
- Reset values: state = IDLE; grid_out all 0; grid_we, busy, done = 0; lines_cleared = 0; score = 0.
- Reset asserted mid-pass aborts immediately. No grid_we is issued, and the owner's grid is untouched.

## Timing
- Start accepted at cycle 0. The first SCAN is cycle 1.
- Busy cycles = GRID_H scans + N rescans + Σ(y_i+1) shift cycles + 1 DONE, where N is the number of cleared rows at rows y_i.
- With no full rows: busy for cycles 1-23, DONE at cycle 23.
- grid_out is stable from DONE until the next accepted start.
- All outputs are registered. There is no combinational path from start or grid_in to any output.

## Configuration
- LINE_CLEAR_SCORE_EN defined: at DONE, score += table[lines_cleared]. The table is 0→0, 1→40, 2→100, 3→300, ≥4→1200. score saturates at 2^SCORE_W-1 and clears only on reset.
- LINE_CLEAR_SCORE_EN undefined: the score port is present and tied to 0, and no score logic is synthesized.

## Structure
- Shared package tetris_pkg holds:
  - GRID_W and GRID_H.
  - typedef cell_t (logic [3:0]).
  - Constants CELL_EMPTY, CELL_ACTIVE, CELL_LOCKED.
  - The row_t type (cell_t [GRID_W]).
  - The line-clear state enum.
  - The score table constants.
- One sub-module, row_full_detect: combinational, row_t in, full out. It is instantiated once on the row selected by y.

## Test plan
- Empty grid, start: busy for exactly 23 cycles, lines_cleared=0, grid_out == grid_in, a single grid_we pulse.
- Row 21 full, cell (0,20)=2, start: busy 46 cycles. lines_cleared=1, grid_out(0,21)=2, row 20 empty, score=40 (with macro).
- Rows 18-21 full, nothing else occupied: lines_cleared=4, grid_out all empty, score=1200 (with macro), score=0 (without).
- start pulsed again at cycle 5 of a pass: ignored; exactly one done pulse; result unchanged.
- Reset_n low at cycle 10 of a pass: all outputs 0 asynchronously, no grid_we. A new start after release completes normally.
- Score saturation: preload near max via repeated 4-line passes; score stops at 0xFFFF and never wraps.
